// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall encodings, FSM state codes,
// the ERET exception code and the stall priority encoder.
package pipe_ctrl_pkg;

  // Stall vector encodings, bit order [5]WB [4]MEM [3]EX [2]ID [1]IF [0]PC
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  // The deepest requesting stage wins: it holds itself and everything upstream.
  function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    logic [5:0] enc;
    if (req_mem)     enc = STALL_MEM;
    else if (req_ex) enc = STALL_EX;
    else if (req_id) enc = STALL_ID;
    else if (req_if) enc = STALL_IF;
    else             enc = STALL_NONE;
    return enc;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Consecutive-stall counter with a sticky timeout flag; the counter saturates
// rather than wrapping so a very long stall can never re-arm a low count.
module stall_watchdog #(
  parameter int STALL_TIMEOUT = 1023,
  parameter int CNT_W         = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic count_clr,
  output logic stall_timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(STALL_TIMEOUT);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             flag_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (count_clr)
      cnt_next = '0;
    else if (count_en && (cnt_reg != {CNT_W{1'b1}}))
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      flag_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (cnt_next == TIMEOUT_CNT)
        flag_reg <= 1'b1;
    end
  end

  assign stall_timeout = flag_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, runs the freeze-then-flush
// exception/ERET redirect and feeds the consecutive-stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          STALL_TIMEOUT = 1023,
  parameter int          CNT_W         = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
);

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] new_pc_reg;
  logic        any_req;
  logic        take_exc;
  logic        count_en;
  logic        count_clr;

  assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

  always_comb begin
    state_next = state_reg;
    stall      = STALL_NONE;
    flush      = 1'b0;
    take_exc   = 1'b0;
    count_en   = 1'b0;
    count_clr  = 1'b0;
    case (state_reg)
      ST_RUN, ST_STALL: begin
        stall     = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        // A stalled cycle counts from its first cycle, the one that moves the FSM into STALL.
        count_en  = any_req;
        count_clr = ~any_req;
        if (excepttype_i != 32'd0) begin
          state_next = ST_FREEZE;
          take_exc   = 1'b1;
        end else if (any_req) begin
          state_next = ST_STALL;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_FREEZE: begin
        stall      = STALL_ALL;
        count_clr  = 1'b1;
        state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush      = 1'b1;
        count_clr  = 1'b1;
        state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
    // Outputs must fall the moment reset asserts, not at the next edge.
    if (!rst) begin
      stall = STALL_NONE;
      flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= ST_RUN;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      new_pc_reg <= 32'd0;
    else if (take_exc)
      new_pc_reg <= (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
  end

  assign new_pc = new_pc_reg;

  stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .count_en      (count_en),
    .count_clr     (count_clr),
    .stall_timeout (stall_timeout)
  );

endmodule
